// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Registered, handshaked instruction decode stage. It takes instruction words
// from fetch over valid/ready and decodes them into register indices, a
// sign-extended immediate, a one-hot instruction class and an illegal flag.
// The decoded payload sits in an output register (OR) backed by a one-entry
// skid register (SR). With the skid entry enabled, in_ready comes straight
// from a flop, so there is no combinational path from out_ready to in_ready.
// A flush discards everything held plus any instruction accepted in the same
// cycle.
//
// Parameters
//   INSTR_SIZE : instruction word width
//   PC_SIZE    : program-counter width carried with each instruction
//   SKID_EN    : 1 = registered in_ready with skid entry,
//                0 = pass-through ready, no skid storage
//
// Ports
//   clk, rst               : clock, asynchronous active-high reset
//   flush                  : drop all held and incoming instructions
//   in_valid/in_ready      : fetch-side handshake
//   in_instr, in_pc        : instruction word and its PC
//   out_valid/out_ready    : issue-side handshake
//   out_pc                 : PC of the decoded instruction
//   out_rs1/out_rs2/out_rd : instr[19:15], instr[24:20], instr[11:7]
//   out_imm                : sign-extended immediate selected by format
//   out_class              : one-hot {JUMP,MUL,LOAD,STORE,BRANCH,ALU_IMM,ALU}
//   out_funct3/out_funct7  : instr[14:12], instr[31:25]
//   out_rd_we              : instruction writes a non-zero rd
//   out_illegal            : opcode not recognised (out_class = 0)
// -----------------------------------------------------------------------------

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ARCH_REG_INDEX_SIZE
`define ARCH_REG_INDEX_SIZE 5
`endif
`ifndef OPCODE_ALU
`define OPCODE_ALU     7'b0110011
`endif
`ifndef OPCODE_ALU_IMM
`define OPCODE_ALU_IMM 7'b0010011
`endif
`ifndef OPCODE_BRANCH
`define OPCODE_BRANCH  7'b1100011
`endif
`ifndef OPCODE_STORE
`define OPCODE_STORE   7'b0100011
`endif
`ifndef OPCODE_LOAD
`define OPCODE_LOAD    7'b0000011
`endif
`ifndef OPCODE_MUL
`define OPCODE_MUL     7'b0001011
`endif
`ifndef OPCODE_JUMP
`define OPCODE_JUMP    7'b1101111
`endif

module decode_stage #(
  parameter int INSTR_SIZE = `WORD_SIZE,
  parameter int PC_SIZE    = `WORD_SIZE,
  parameter bit SKID_EN    = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [INSTR_SIZE-1:0]           in_instr,
  input  logic [PC_SIZE-1:0]              in_pc,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PC_SIZE-1:0]              out_pc,
  output logic [`ARCH_REG_INDEX_SIZE-1:0] out_rs1,
  output logic [`ARCH_REG_INDEX_SIZE-1:0] out_rs2,
  output logic [`ARCH_REG_INDEX_SIZE-1:0] out_rd,
  output logic [`WORD_SIZE-1:0]           out_imm,
  output logic [6:0]                      out_class,
  output logic [2:0]                      out_funct3,
  output logic [6:0]                      out_funct7,
  output logic                            out_rd_we,
  output logic                            out_illegal
);

  localparam logic [6:0] CLS_ALU     = 7'b0000001;
  localparam logic [6:0] CLS_ALU_IMM = 7'b0000010;
  localparam logic [6:0] CLS_BRANCH  = 7'b0000100;
  localparam logic [6:0] CLS_STORE   = 7'b0001000;
  localparam logic [6:0] CLS_LOAD    = 7'b0010000;
  localparam logic [6:0] CLS_MUL     = 7'b0100000;
  localparam logic [6:0] CLS_JUMP    = 7'b1000000;
  // Classes that write a destination register.
  localparam logic [6:0] RD_WE_MASK  = CLS_ALU | CLS_ALU_IMM | CLS_LOAD | CLS_MUL | CLS_JUMP;

  typedef struct packed {
    logic [PC_SIZE-1:0]              pc;
    logic [`ARCH_REG_INDEX_SIZE-1:0] rs1;
    logic [`ARCH_REG_INDEX_SIZE-1:0] rs2;
    logic [`ARCH_REG_INDEX_SIZE-1:0] rd;
    logic [`WORD_SIZE-1:0]           imm;
    logic [6:0]                      cls;
    logic [2:0]                      funct3;
    logic [6:0]                      funct7;
    logic                            rd_we;
    logic                            illegal;
  } payload_t;

  function automatic payload_t decode(input logic [INSTR_SIZE-1:0] instr,
                                      input logic [PC_SIZE-1:0]    pc);
    payload_t p;
    p        = '0;
    p.pc     = pc;
    p.rs1    = instr[19:15];
    p.rs2    = instr[24:20];
    p.rd     = instr[11:7];
    p.funct3 = instr[14:12];
    p.funct7 = instr[31:25];
    case (instr[6:0])
      `OPCODE_ALU:     p.cls = CLS_ALU;
      `OPCODE_MUL:     p.cls = CLS_MUL;
      `OPCODE_ALU_IMM: begin
        p.cls = CLS_ALU_IMM;
        p.imm = {{20{instr[31]}}, instr[31:20]};
      end
      `OPCODE_LOAD: begin
        p.cls = CLS_LOAD;
        p.imm = {{20{instr[31]}}, instr[31:20]};
      end
      `OPCODE_STORE: begin
        p.cls = CLS_STORE;
        p.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      `OPCODE_BRANCH: begin
        p.cls = CLS_BRANCH;
        p.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      `OPCODE_JUMP: begin
        p.cls = CLS_JUMP;
        p.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: p.illegal = 1'b1;
    endcase
    p.rd_we = (|(p.cls & RD_WE_MASK)) && (p.rd != '0);
    return p;
  endfunction

  payload_t or_q, or_d, sr_q, sr_d, dec;
  logic     or_valid_q, or_valid_d;
  logic     sr_valid_q, sr_valid_d;
  logic     in_ready_q, in_ready_d;
  logic     accept, consume;

  assign dec     = decode(in_instr, in_pc);
  assign accept  = in_valid && in_ready;
  assign consume = or_valid_q && out_ready;

  // NOTE: every signal driven here gets a default first, so no path through
  // the branches leaves it unassigned and no latch is inferred.
  always_comb begin
    or_d       = or_q;
    sr_d       = sr_q;
    or_valid_d = or_valid_q;
    sr_valid_d = sr_valid_q;
    if (flush) begin
      // Flush beats accept and consume: both entries empty, input dropped.
      or_valid_d = 1'b0;
      sr_valid_d = 1'b0;
    end else if (!or_valid_q || consume) begin
      // OR is free this cycle; the oldest instruction moves in first.
      if (sr_valid_q) begin
        or_d       = sr_q;
        or_valid_d = 1'b1;
        sr_valid_d = 1'b0;
      end else if (accept) begin
        or_d       = dec;
        or_valid_d = 1'b1;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (accept && SKID_EN) begin
      // OR is stalled: park the newcomer in the skid entry.
      sr_d       = dec;
      sr_valid_d = 1'b1;
    end
    in_ready_d = !sr_valid_d;
  end

  // NOTE: the payload registers are reset too, because the payload outputs
  // must read zero out of reset rather than whatever the flops power up with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      or_q       <= '0;
      sr_q       <= '0;
      or_valid_q <= 1'b0;
      sr_valid_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      or_q       <= or_d;
      sr_q       <= sr_d;
      or_valid_q <= or_valid_d;
      sr_valid_q <= sr_valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = SKID_EN ? in_ready_q : (!or_valid_q || out_ready);
  assign out_valid   = or_valid_q;
  assign out_pc      = or_q.pc;
  assign out_rs1     = or_q.rs1;
  assign out_rs2     = or_q.rs2;
  assign out_rd      = or_q.rd;
  assign out_imm     = or_q.imm;
  assign out_class   = or_q.cls;
  assign out_funct3  = or_q.funct3;
  assign out_funct7  = or_q.funct7;
  assign out_rd_we   = or_q.rd_we;
  assign out_illegal = or_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm;
  logic [6:0]  out_class;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic        out_rd_we;
  logic        out_illegal;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_class(out_class), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rd_we(out_rd_we), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;
  int consumed_cnt  = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  // Reference FIFO: entries are {pc, instr}; pc values are unique per test.
  logic [63:0] model_q[$];

  // Handshakes are observed at the falling edge, where inputs and outputs are
  // both settled for the coming rising edge.
  always @(negedge clk) begin
    if (rst || flush) begin
      model_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        consumed_cnt++;
        check("consume_nonempty", 64'(model_q.size() != 0), 64'd1);
        if (model_q.size() != 0) begin
          logic [63:0] e;
          e = model_q.pop_front();
          check("fifo_order",
                {out_pc, out_rd, out_rs1, out_rs2, out_funct3, out_funct7},
                {e[63:32], e[11:7], e[19:15], e[24:20], e[14:12], e[31:25]});
        end
      end
      if (in_valid && in_ready) model_q.push_back({in_pc, in_instr});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and hold it until accepted, bounded.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    int budget;
    budget   = 20;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    while (!in_ready && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check("send_timeout", 64'd0, 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [6:0]  cls;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        we;
    logic        ill;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{32'h002081B3, 32'h100, 5'd1, 5'd2,  5'd3,  32'h0,        7'h01, 3'd0, 7'h00, 1'b1, 1'b0}; // ADD x3,x1,x2
    vecs[1] = '{32'h00812283, 32'h104, 5'd2, 5'd8,  5'd5,  32'h8,        7'h10, 3'd2, 7'h00, 1'b1, 1'b0}; // LW x5,8(x2)
    vecs[2] = '{32'hFE208CE3, 32'h108, 5'd1, 5'd2,  5'd25, 32'hFFFFFFF8, 7'h04, 3'd0, 7'h7F, 1'b0, 1'b0}; // BEQ -8
    vecs[3] = '{32'h0000007F, 32'h10C, 5'd0, 5'd0,  5'd0,  32'h0,        7'h00, 3'd0, 7'h00, 1'b0, 1'b1}; // illegal
    vecs[4] = '{32'h00000013, 32'h110, 5'd0, 5'd0,  5'd0,  32'h0,        7'h02, 3'd0, 7'h00, 1'b0, 1'b0}; // ADDI x0
    vecs[5] = '{32'hFE512E23, 32'h114, 5'd2, 5'd5,  5'd28, 32'hFFFFFFFC, 7'h08, 3'd2, 7'h7F, 1'b0, 1'b0}; // SW x5,-4(x2)
    vecs[6] = '{32'h010000EF, 32'h118, 5'd0, 5'd16, 5'd1,  32'h10,       7'h40, 3'd0, 7'h00, 1'b1, 1'b0}; // JAL x1,+16
    vecs[7] = '{32'h0232030B, 32'h11C, 5'd4, 5'd3,  5'd6,  32'h0,        7'h20, 3'd0, 7'h01, 1'b1, 1'b0}; // MUL x6,x4,x3
    vecs[8] = '{32'hFFF00393, 32'h120, 5'd0, 5'd31, 5'd7,  32'hFFFFFFFF, 7'h02, 3'd0, 7'h7F, 1'b1, 1'b0}; // ADDI x7,x0,-1
    vecs[9] = '{32'h000012B7, 32'h124, 5'd0, 5'd0,  5'd5,  32'h0,        7'h00, 3'd1, 7'h00, 1'b0, 1'b1}; // LUI: illegal

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    #12 rst = 1'b0;
    step();

    // Reset state.
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_payload",   {out_pc, out_imm}, 64'd0);
    check("rst_class",     {out_class, out_rd, out_rd_we, out_illegal}, 64'd0);

    // Decode vectors, one per cycle at full throughput.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = vecs[i].pc;
      step();
      check("vec_valid",   64'(out_valid),   64'd1);
      check("vec_pc",      64'(out_pc),      64'(vecs[i].pc));
      check("vec_regs",    {out_rs1, out_rs2, out_rd}, {vecs[i].rs1, vecs[i].rs2, vecs[i].rd});
      check("vec_imm",     64'(out_imm),     64'(vecs[i].imm));
      check("vec_class",   64'(out_class),   64'(vecs[i].cls));
      check("vec_funct",   {out_funct3, out_funct7}, {vecs[i].f3, vecs[i].f7});
      check("vec_rd_we",   64'(out_rd_we),   64'(vecs[i].we));
      check("vec_illegal", 64'(out_illegal), 64'(vecs[i].ill));
    end
    in_valid = 1'b0;
    step();
    check("vec_drained", 64'(out_valid), 64'd0);
    check("vec_consumed", 64'(consumed_cnt), 64'd10);

    // Backpressure: 2 held, in_ready drops, then all 4 emerge in order.
    consumed_cnt = 0;
    out_ready = 1'b0;
    send(32'h00100093, 32'h200);
    check("bp_or_pc",   64'(out_pc), 64'h200);
    check("bp_ready1",  64'(in_ready), 64'd1);
    send(32'h00200113, 32'h204);
    check("bp_ready0",  64'(in_ready), 64'd0);
    in_valid = 1'b1; in_instr = 32'h00300193; in_pc = 32'h208;
    step(); step();
    check("bp_hold_pc",  64'(out_pc), 64'h200);
    check("bp_hold_rd",  64'(out_rd), 64'd1);
    check("bp_still0",   64'(in_ready), 64'd0);
    check("bp_none_out", 64'(consumed_cnt), 64'd0);
    out_ready = 1'b1;
    step();
    check("bp_or_from_sr", 64'(out_pc), 64'h204);
    check("bp_ready_back", 64'(in_ready), 64'd1);
    step();
    in_instr = 32'h00400213; in_pc = 32'h20C;
    step();
    in_valid = 1'b0;
    step(); step();
    check("bp_all_out", 64'(consumed_cnt), 64'd4);
    check("bp_empty",   64'(out_valid), 64'd0);

    // Flush with OR and SR full and a new word presented.
    consumed_cnt = 0;
    out_ready = 1'b0;
    send(32'h00500293, 32'h300);
    send(32'h00600313, 32'h304);
    in_valid = 1'b1; in_instr = 32'h00700393; in_pc = 32'h308; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    // Flush in the same cycle as a real accept into an empty stage.
    in_valid = 1'b1; in_instr = 32'h00800413; in_pc = 32'h30C; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_accept_dropped", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    step(); step();
    check("flush_none_seen", 64'(consumed_cnt), 64'd0);

    // Asynchronous reset between edges.
    out_ready = 1'b0;
    send(32'h00900493, 32'h400);
    check("arst_pre_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid",   64'(out_valid), 64'd0);
    check("arst_ready",   64'(in_ready),  64'd1);
    check("arst_payload", 64'(out_pc),    64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00A00513; in_pc = 32'h404;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("arst_first_accept", {out_valid, out_pc}, {1'b1, 32'h404});
    out_ready = 1'b1;
    step();

    // Random valid/ready/flush stress against the reference FIFO.
    begin
      logic [31:0] pc_next;
      pc_next = 32'h1000;
      for (int c = 0; c < 10000; c++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        flush     = ($urandom_range(0, 99) == 0);
        in_instr  = $urandom;
        in_pc     = pc_next;
        if (in_valid && in_ready) pc_next = pc_next + 4;
        step();
      end
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    check("stress_drained", 64'(model_q.size()), 64'd0);
    check("stress_out_valid", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
